// File: rtl/mealy_seq_controller.sv
// mealy_seq_controller
//
// Drives the serial input of a single-bit Mealy detector with a captured bit
// pattern (LSB first), clears the detector before each run, and counts the
// detector's output pulses while the pattern is being shifted out.
//
// Run shape for an accepted start with effective length L:
//   IDLE -> CLEAR (1 cycle) -> SHIFT (L cycles) -> DONE (1 cycle) -> IDLE
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   run request, only looked at in IDLE
//   pattern      in   PAT_W bits to send, bit 0 first
//   length       in   CNT_W number of bits to send (clamped to PAT_W)
//   aout         in   detector output (combinational from ain)
//   ain          out  serial bit to the detector (registered)
//   det_reset    out  detector clear, high in CLEAR and while reset is high
//   busy         out  high through CLEAR and all SHIFT cycles
//   done         out  one-cycle pulse in the DONE cycle
//   match_count  out  detector hits of the last run, held until next start

module mealy_seq_controller #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] length,
  input  logic             aout,
  output logic             ain,
  output logic             det_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(PAT_W);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};

  state_e           state_q;
  logic [PAT_W-1:0] shreg_q;   // remaining bits, next bit to send in [0]
  logic [CNT_W-1:0] bitcnt_q;  // SHIFT cycles still to run, including the current one
  logic             ain_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] eff_len_s;

  // Clamp the requested length to the shift register width.
  always_comb begin
    eff_len_s = length;
    if (length > MAX_LEN) begin
      eff_len_s = MAX_LEN;
    end else begin
      eff_len_s = length;
    end
  end

  // Run sequencer: state, shift register, bit counter and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= {PAT_W{1'b0}};
      bitcnt_q <= ZERO;
      ain_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ain_q  <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            shreg_q  <= pattern;
            bitcnt_q <= eff_len_s;
            match_q  <= ZERO;
            busy_q   <= 1'b1;
            state_q  <= ST_CLEAR;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (bitcnt_q == ZERO) begin
            // Zero-length run: nothing to shift, finish straight away.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ain_q   <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            ain_q   <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[PAT_W-1:1]};
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // aout reflects the bit presented during this cycle.
          if (aout) begin
            match_q <= match_q + ONE;
          end else begin
            match_q <= match_q;
          end
          bitcnt_q <= bitcnt_q - ONE;
          if (bitcnt_q == ONE) begin
            ain_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            ain_q   <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[PAT_W-1:1]};
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ain_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ain_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          match_q <= ZERO;
        end
      endcase
    end
  end

  // The detector must also be held clear for the whole of our own reset.
  assign det_reset   = reset | (state_q == ST_CLEAR);
  assign ain         = ain_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_count = match_q;

endmodule

// File: tb/tb_mealy_seq_controller.sv
module tb_mealy_seq_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = 16'h0000;
  logic [4:0]  length = 5'd0;
  logic        aout;
  logic        ain;
  logic        det_reset;
  logic        busy;
  logic        done;
  logic [4:0]  match_count;

  int n_vec  = 0;
  int n_fail = 0;

  mealy_seq_controller #(.PAT_W(16), .CNT_W(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pattern     (pattern),
    .length      (length),
    .aout        (aout),
    .ain         (ain),
    .det_reset   (det_reset),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  always #5 clock = ~clock;

  // Behavioural rising-edge detector standing in for the real Mealy detector.
  logic det_prev = 1'b0;
  always @(posedge clock) det_prev <= det_reset ? 1'b0 : ain;
  assign aout = ain & ~det_prev;

  // ---------------- reference model (run timeline) ----------------
  bit          m_active = 0;
  int          m_t      = 0;   // 1 = clear cycle, 2..L+1 shift, L+2 done
  logic [15:0] m_pat    = 16'h0000;
  int          m_len    = 0;
  int          m_held   = 0;

  // Rising edges among the first n bits of p, starting from a cleared detector.
  function automatic int hits(input logic [15:0] p, input int n);
    int h;
    h = 0;
    for (int i = 0; i < n; i++) begin
      if (p[i] == 1'b1) begin
        if (i == 0) h++;
        else if (p[i-1] == 1'b0) h++;
      end
    end
    return h;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_active = 0;
      m_held   = 0;
    end else if (m_active) begin
      if (m_t == m_len + 2) begin
        m_active = 0;
        m_held   = hits(m_pat, m_len);
      end else begin
        m_t++;
      end
    end else if (start) begin
      m_active = 1;
      m_t      = 1;
      m_pat    = pattern;
      m_len    = (int'(length) > 16) ? 16 : int'(length);
      m_held   = 0;
    end
  endtask

  // Per-cycle compare of every output against the model, mid-cycle.
  initial begin
    int e_ain, e_busy, e_done, e_match, e_clr;
    forever begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      e_ain = 0; e_busy = 0; e_done = 0; e_clr = 0; e_match = m_held;
      if (m_active) begin
        if (m_t == 1) begin
          e_busy = 1; e_clr = 1; e_match = 0;
        end else if (m_t <= m_len + 1) begin
          e_busy  = 1;
          e_ain   = int'(m_pat[m_t-2]);
          e_match = hits(m_pat, m_t - 2);
        end else begin
          e_done  = 1;
          e_match = hits(m_pat, m_len);
        end
      end
      check("ain", int'(ain), e_ain);
      check("busy", int'(busy), e_busy);
      check("done", int'(done), e_done);
      check("match_count", int'(match_count), e_match);
      check("det_reset", int'(det_reset), (reset ? 1 : e_clr));
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic run_and_check(input logic [15:0] pat, input logic [4:0] len,
                               input int exp_match, input int exp_lat,
                               input int exp_busy, input int poke, input string name);
    int cnt, nbusy, ndet, extra;
    pattern = pat; length = len; start = 1'b1;
    cycle();
    start = 1'b0;
    cnt = 1; nbusy = 0; ndet = 0;
    while (done !== 1'b1 && cnt < 40) begin
      if (busy === 1'b1) nbusy++;
      if (det_reset === 1'b1) ndet++;
      if (cnt == poke) begin
        start = 1'b1; pattern = 16'hFFFF; length = 5'd3;
      end else begin
        start = 1'b0;
      end
      cycle();
      cnt++;
    end
    start = 1'b0;
    check({name, "_done"}, int'(done), 1);
    check({name, "_latency"}, cnt, exp_lat);
    check({name, "_busy_cycles"}, nbusy, exp_busy);
    check({name, "_det_reset_cycles"}, ndet, 1);
    check({name, "_count"}, int'(match_count), exp_match);
    extra = 0;
    repeat (5) begin
      cycle();
      if (done === 1'b1) extra++;
    end
    check({name, "_extra_done"}, extra, 0);
    check({name, "_count_held"}, int'(match_count), exp_match);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    check(name, int'(done), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nd;
    reset = 1'b1;
    repeat (3) cycle();
    check("reset_det_reset", int'(det_reset), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ain", int'(ain), 0);
    check("reset_count", int'(match_count), 0);
    reset = 1'b0;
    cycle();

    run_and_check(16'h0005, 5'd4, 2, 6, 5, -1, "basic");
    run_and_check(16'hAAAA, 5'd16, 8, 18, 17, -1, "alt16");
    run_and_check(16'hFFFF, 5'd16, 1, 18, 17, -1, "ones16");
    run_and_check(16'hFFFF, 5'd0, 0, 2, 1, -1, "len0");
    run_and_check(16'hFFFF, 5'd20, 1, 18, 17, -1, "len20");
    run_and_check(16'hAAAA, 5'd16, 8, 18, 17, 6, "start_busy");

    // Reset during the third SHIFT cycle.
    pattern = 16'hAAAA; length = 5'd16; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_ain", int'(ain), 0);
    check("abort_done", int'(done), 0);
    check("abort_count", int'(match_count), 0);
    nd = 0;
    repeat (20) begin
      cycle();
      if (done === 1'b1) nd++;
    end
    check("abort_no_done", nd, 0);
    run_and_check(16'hAAAA, 5'd16, 8, 18, 17, -1, "after_abort");

    // Back-to-back runs with start held high.
    pattern = 16'h000A; length = 5'd4; start = 1'b1;
    cycle();
    wait_done(30, "b2b_first_done");
    check("b2b_first_count", int'(match_count), 2);
    pattern = 16'h0007; length = 5'd5;
    cycle();
    check("b2b_idle_det", int'(det_reset), 0);
    check("b2b_idle_busy", int'(busy), 0);
    cycle();
    check("b2b_clear_det", int'(det_reset), 1);
    check("b2b_clear_count", int'(match_count), 0);
    start = 1'b0;
    wait_done(30, "b2b_second_done");
    check("b2b_second_count", int'(match_count), 1);
    repeat (3) cycle();

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 59) == 0);
      pattern = 16'($urandom);
      length  = 5'($urandom_range(0, 31));
      cycle();
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (25) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
